// File: rtl/uart_pkg.sv
// UART shared definitions: parity modes, oversampling constants,
// sample points, FSM encoding and baud divider helper.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam int OS_RATE = 16;

  localparam logic [3:0] SC_S0   = 4'd7;
  localparam logic [3:0] SC_S1   = 4'd8;
  localparam logic [3:0] SC_S2   = 4'd9;
  localparam logic [3:0] SC_LAST = 4'd15;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  function automatic int uart_div(input int clk_hz, input int baud);
    return clk_hz / (baud * OS_RATE);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-clock pulse every DIV clocks.
// Shared between the UART receiver and transmitter.
module uart_baud_tick #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic os_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // free-running divider, wraps at DIV-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign os_tick = en && (cnt == LAST);

endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampled UART receiver with majority vote, parity,
// framing/overrun status and a valid/ready word output.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int DIV = uart_div(CLK_HZ, BAUD);
  localparam int BW  = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_rx_os: DIV must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("uart_rx_os: DATA_BITS must be 5..9");
  end
  if (PARITY < PARITY_NONE || PARITY > PARITY_EVEN) begin : g_bad_par
    $error("uart_rx_os: PARITY must be 0..2");
  end

  logic                 rx_m;
  logic                 rx_s;
  logic                 os_tick;
  logic [2:0]           state;
  logic [3:0]           sc;
  logic [BW-1:0]        bidx;
  logic [DATA_BITS-1:0] shreg;
  logic [2:0]           smp;
  logic                 par_q;
  logic                 armed;
  logic                 maj_st;
  logic                 maj_live;
  logic                 commit;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .en      (1'b1),
    .os_tick (os_tick)
  );

  // two-stage synchroniser, idles high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= uart_rx;
      rx_s <= rx_m;
    end
  end

  assign maj_st = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
  assign maj_live = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);
  assign commit = os_tick && (state == ST_STOP) && (sc == SC_S2);

  // frame FSM; armed blocks re-triggering while a break holds the line low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      sc      <= '0;
      bidx    <= '0;
      shreg   <= '0;
      smp     <= '0;
      par_q   <= 1'b0;
      armed   <= 1'b1;
      rx_busy <= 1'b0;
    end else if (os_tick) begin
      if (state != ST_IDLE) begin
        sc <= sc + 4'd1;
        if (sc == SC_S0) smp[0] <= rx_s;
        if (sc == SC_S1) smp[1] <= rx_s;
        if (sc == SC_S2) smp[2] <= rx_s;
      end
      unique case (state)
        ST_IDLE: begin
          if (rx_s) armed <= 1'b1;
          if (armed && !rx_s) begin
            state   <= ST_START;
            sc      <= '0;
            bidx    <= '0;
            par_q   <= 1'b0;
            rx_busy <= 1'b1;
          end
        end
        ST_START: begin
          if (sc == SC_LAST) begin
            if (!maj_st) begin
              state <= ST_DATA;
            end else begin
              state   <= ST_IDLE;
              rx_busy <= 1'b0;
            end
          end
        end
        ST_DATA: begin
          if (sc == SC_LAST) begin
            shreg <= {maj_st, shreg[DATA_BITS-1:1]};
            bidx  <= bidx + BW'(1);
            if (bidx == LAST_BIT) begin
              state <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end
          end
        end
        ST_PARITY: begin
          if (sc == SC_LAST) begin
            par_q <= (((^shreg) ^ maj_st) != (PARITY == PARITY_ODD));
            state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (sc == SC_S2) begin
            state   <= ST_IDLE;
            rx_busy <= 1'b0;
            if (!maj_live) armed <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

  // output holding register with valid/ready handshake and overrun pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (commit) begin
        if (!rx_valid || rx_ready) begin
          rx_data       <= shreg;
          rx_frame_err  <= ~maj_live;
          rx_parity_err <= par_q;
          rx_valid      <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: 8N1 and 8E1 instances,
// vector table plus glitch, overrun, reset and break sequences.
module tb_uart_rx_os;

  localparam int CLK_HZ  = 16_000_000;
  localparam int BAUD    = 500_000;
  localparam int BIT_CLK = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ln0 = 1'b1;
  logic       ln1 = 1'b1;
  logic       rdy0 = 1'b1;
  logic       rdy1 = 1'b1;
  logic [7:0] d0, d1;
  logic       v0, v1, fe0, fe1, pe0, pe1, ov0, ov1, bz0, bz1;

  uart_rx_os #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0)
  ) u0 (
    .clk(clk), .rst(rst), .uart_rx(ln0), .rx_data(d0),
    .rx_valid(v0), .rx_ready(rdy0), .rx_frame_err(fe0),
    .rx_parity_err(pe0), .rx_overrun(ov0), .rx_busy(bz0)
  );

  uart_rx_os #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2)
  ) u1 (
    .clk(clk), .rst(rst), .uart_rx(ln1), .rx_data(d1),
    .rx_valid(v1), .rx_ready(rdy1), .rx_frame_err(fe1),
    .rx_parity_err(pe1), .rx_overrun(ov1), .rx_busy(bz1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int acc0 = 0;
  int acc1 = 0;
  int ovc0 = 0;
  logic [7:0] ld0 = '0, ld1 = '0;
  logic lfe0 = 1'b0, lfe1 = 1'b0, lpe0 = 1'b0, lpe1 = 1'b0;

  always @(negedge clk) begin
    if (v0 && rdy0) begin
      acc0 <= acc0 + 1;
      ld0  <= d0;
      lfe0 <= fe0;
      lpe0 <= pe0;
    end
    if (v1 && rdy1) begin
      acc1 <= acc1 + 1;
      ld1  <= d1;
      lfe1 <= fe1;
      lpe1 <= pe1;
    end
    if (ov0) ovc0 <= ovc0 + 1;
  end

  typedef struct {
    bit         w;
    logic [7:0] d;
    bit         hp;
    logic       pb;
    logic       sb;
    logic [7:0] ed;
    logic       efe;
    logic       epe;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ln(input bit w, input logic v);
    if (w) ln1 = v;
    else   ln0 = v;
  endtask

  task automatic send(input bit w, input logic [7:0] d, input bit hp,
                      input logic pb, input logic sb);
    set_ln(w, 1'b0);
    cyc(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      set_ln(w, d[i]);
      cyc(BIT_CLK);
    end
    if (hp) begin
      set_ln(w, pb);
      cyc(BIT_CLK);
    end
    set_ln(w, sb);
    cyc(BIT_CLK);
    set_ln(w, 1'b1);
    cyc(2 * BIT_CLK);
  endtask

  initial begin
    int a;
    int o;
    tbl[0] = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 8'h0F, 1'b0, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 8'h80, 1'b1, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};

    cyc(5);
    chk("rst_valid", {31'd0, v0}, 32'd0);
    chk("rst_data", {24'd0, d0}, 32'd0);
    chk("rst_ferr", {31'd0, fe0}, 32'd0);
    chk("rst_perr", {31'd0, pe1}, 32'd0);
    chk("rst_ovr", {31'd0, ov0}, 32'd0);
    chk("rst_busy", {31'd0, bz0 | bz1}, 32'd0);
    rst = 1'b0;
    cyc(20);

    for (int k = 0; k < 8; k++) begin
      a = tbl[k].w ? acc1 : acc0;
      send(tbl[k].w, tbl[k].d, tbl[k].hp, tbl[k].pb, tbl[k].sb);
      if (tbl[k].w) begin
        chk($sformatf("v%0d_cnt", k), acc1 - a, 32'd1);
        chk($sformatf("v%0d_data", k), {24'd0, ld1}, {24'd0, tbl[k].ed});
        chk($sformatf("v%0d_ferr", k), {31'd0, lfe1}, {31'd0, tbl[k].efe});
        chk($sformatf("v%0d_perr", k), {31'd0, lpe1}, {31'd0, tbl[k].epe});
      end else begin
        chk($sformatf("v%0d_cnt", k), acc0 - a, 32'd1);
        chk($sformatf("v%0d_data", k), {24'd0, ld0}, {24'd0, tbl[k].ed});
        chk($sformatf("v%0d_ferr", k), {31'd0, lfe0}, {31'd0, tbl[k].efe});
        chk($sformatf("v%0d_perr", k), {31'd0, lpe0}, {31'd0, tbl[k].epe});
      end
    end

    a = acc0;
    ln0 = 1'b0;
    cyc(8);
    chk("glitch_busy_hi", {31'd0, bz0}, 32'd1);
    cyc(2);
    ln0 = 1'b1;
    cyc(40);
    chk("glitch_busy_lo", {31'd0, bz0}, 32'd0);
    chk("glitch_novalid", acc0 - a, 32'd0);

    a = acc0;
    o = ovc0;
    rdy0 = 1'b0;
    send(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    send(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    chk("ovr_valid", {31'd0, v0}, 32'd1);
    chk("ovr_data", {24'd0, d0}, 32'h11);
    chk("ovr_pulses", ovc0 - o, 32'd1);
    chk("ovr_noacc", acc0 - a, 32'd0);
    rdy0 = 1'b1;
    cyc(2);
    chk("ovr_acc", acc0 - a, 32'd1);
    chk("ovr_accdata", {24'd0, ld0}, 32'h11);
    chk("ovr_cleared", {31'd0, v0}, 32'd0);

    a = acc0;
    ln0 = 1'b0;
    cyc(BIT_CLK);
    for (int i = 0; i < 3; i++) begin
      ln0 = 1'b1;
      cyc(BIT_CLK);
    end
    chk("mid_busy", {31'd0, bz0}, 32'd1);
    rst = 1'b1;
    cyc(3);
    ln0 = 1'b1;
    chk("mid_rst_busy", {31'd0, bz0}, 32'd0);
    chk("mid_rst_valid", {31'd0, v0}, 32'd0);
    rst = 1'b0;
    cyc(2 * BIT_CLK);
    send(1'b0, 8'h99, 1'b0, 1'b0, 1'b1);
    chk("rst_frame_cnt", acc0 - a, 32'd1);
    chk("rst_frame_data", {24'd0, ld0}, 32'h99);

    a = acc0;
    ln0 = 1'b0;
    cyc(15 * BIT_CLK);
    ln0 = 1'b1;
    cyc(2 * BIT_CLK);
    chk("brk_cnt", acc0 - a, 32'd1);
    chk("brk_data", {24'd0, ld0}, 32'd0);
    chk("brk_ferr", {31'd0, lfe0}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
